mem_access_stage: RTL



---
 rtl/mem_access_stage.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory stage between Execute and WriteBack: issues loads and stores over a req/ack handshake.
// Opcode field is instruction[WIDTH-1 -: 6]. Optional access timeout and mem_error port: define MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  BUBBLE_INSN = 32'h0000_0000
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT     = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction_in,
  input  logic [WIDTH-3:0] progcounter_in,
  input  logic [WIDTH-1:0] aluresult_in,
  input  logic [WIDTH-1:0] dataB_in,
  input  logic             valid_in,
  output logic             stall_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] instruction_out,
  output logic [WIDTH-3:0] progcounter_out,
  output logic [WIDTH-1:0] dataC_out
`ifdef MEM_TIMEOUT_EN
  ,
  output logic             mem_error
`endif
);

  localparam int unsigned PW = WIDTH - 2;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [5:0] OP_LD = 6'h20;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SD = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

  // Access size: 2 = word, 1 = halfword, 0 = byte
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return 2'd2;
      OP_LH, OP_SH: return 2'd1;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd2:    return 4'b1111;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << a;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] load_align(input logic [1:0] sz, input logic [1:0] a,
                                                  input logic [WIDTH-1:0] rd);
    case (sz)
      2'd2:    return rd;
      2'd1:    return a[1] ? WIDTH'(rd[31:16]) : WIDTH'(rd[15:0]);
      default: begin
        case (a)
          2'd0:    return WIDTH'(rd[7:0]);
          2'd1:    return WIDTH'(rd[15:8]);
          2'd2:    return WIDTH'(rd[23:16]);
          default: return WIDTH'(rd[31:24]);
        endcase
      end
    endcase
  endfunction

  logic [0:0]       state_q, state_d;
  logic             req_q, req_d, we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [WIDTH-1:0] ea_q, ea_d, insn_lat_q, insn_lat_d;
  logic [PW-1:0]    pc_lat_q, pc_lat_d;
  logic [WIDTH-1:0] insn_out_q, insn_out_d, datac_q, datac_d;
  logic [PW-1:0]    pc_out_q, pc_out_d;

  logic [5:0]       op_in, op_lat;
  logic             in_is_mem, done_c;
  logic [WIDTH-1:0] wdata_c;

  assign op_in     = instruction_in[WIDTH-1 -: 6];
  assign op_lat    = insn_lat_q[WIDTH-1 -: 6];
  assign in_is_mem = is_load(op_in) || is_store(op_in);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout_c;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT));
  assign done_c    = mem_ack || timeout_c;
  assign mem_error = err_q;
`else
  assign done_c    = mem_ack;
`endif

  // Store data replicated across every lane of the access width
  always_comb begin
    case (op_size(op_in))
      2'd2:    wdata_c = dataB_in;
      2'd1:    wdata_c = {2{dataB_in[15:0]}};
      default: wdata_c = {4{dataB_in[7:0]}};
    endcase
  end

  assign stall_out = ((state_q == S_IDLE) && valid_in && in_is_mem) ||
                     ((state_q == S_ACCESS) && !done_c);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ea_d       = ea_q;
    insn_lat_d = insn_lat_q;
    pc_lat_d   = pc_lat_q;
    insn_out_d = BUBBLE_INSN;
    pc_out_d   = '0;
    datac_d    = '0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_in && in_is_mem) begin
          state_d    = S_ACCESS;
          req_d      = 1'b1;
          we_d       = is_store(op_in);
          be_d       = lane_be(op_size(op_in), aluresult_in[1:0]);
          addr_d     = {aluresult_in[WIDTH-1:2], 2'b00};
          wdata_d    = wdata_c;
          ea_d       = aluresult_in;
          insn_lat_d = instruction_in;
          pc_lat_d   = progcounter_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else if (valid_in) begin
          insn_out_d = instruction_in;
          pc_out_d   = progcounter_in;
          datac_d    = aluresult_in;
        end
      end
      default: begin
        if (done_c) begin
          state_d    = S_IDLE;
          req_d      = 1'b0;
          insn_out_d = insn_lat_q;
          pc_out_d   = pc_lat_q;
          datac_d    = is_load(op_lat) ? load_align(op_size(op_lat), ea_q[1:0], mem_rdata) : ea_q;
`ifdef MEM_TIMEOUT_EN
          if (!mem_ack) begin
            err_d = 1'b1;
            if (is_load(op_lat)) datac_d = WIDTH'(32'hDEAD_BEEF);
          end
`endif
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ea_q       <= '0;
      insn_lat_q <= BUBBLE_INSN;
      pc_lat_q   <= '0;
      insn_out_q <= BUBBLE_INSN;
      pc_out_q   <= '0;
      datac_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ea_q       <= ea_d;
      insn_lat_q <= insn_lat_d;
      pc_lat_q   <= pc_lat_d;
      insn_out_q <= insn_out_d;
      pc_out_q   <= pc_out_d;
      datac_q    <= datac_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign mem_req         = req_q;
  assign mem_we          = we_q;
  assign mem_be          = be_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign instruction_out = insn_out_q;
  assign progcounter_out = pc_out_q;
  assign dataC_out       = datac_q;

endmodule
